// File: rtl/overlay_fetch.sv
// overlay_fetch
//   Streams packed overlay pixels from word-wide SDRAM to the blend stage.
//   Words are fetched through a single-outstanding level request / pulse ack
//   port. They are buffered in a small FIFO, then unpacked low pixel first.
//   One pixel is presented per active ce_pix. The stream restarts at BASE on
//   every vsync rising edge, and the block is held flushed while enable is low.
//
// Ports
//   clk, rst_n          video clock, asynchronous active-low reset
//   enable              overlay present; 0 holds the block flushed
//   ce_pix              pixel clock enable
//   hblank, vblank      active-high blanking (ce_pix in blanking outputs 0)
//   vsync               active-high vertical sync; rising edge restarts frame
//   repeat2             show every pixel for two active ce_pix
//   mem_req/mem_addr    read request level and word address (stable while req)
//   mem_ack/mem_data    one-cycle ack pulse with read data
//   pix_out             registered overlay pixel
//   underflow           sticky per frame: pixel demanded while FIFO empty
module overlay_fetch #(
    parameter int              AW    = 24,
    parameter int              DW    = 32,
    parameter int              PW    = 16,
    parameter int              DEPTH = 4,
    parameter logic [AW-1:0]   BASE  = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          ce_pix,
    input  logic          hblank,
    input  logic          vblank,
    input  logic          vsync,
    input  logic          repeat2,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_data,
    output logic [PW-1:0] pix_out,
    output logic          underflow
);

    localparam int N    = DW / PW;
    localparam int SW   = (N > 1) ? $clog2(N) : 1;
    localparam int PTRW = $clog2(DEPTH);
    localparam int CW   = PTRW + 1;

    logic            vsync_prev_q, vsync_prev_d;
    logic            mem_req_q, mem_req_d;
    logic            outstanding_q, outstanding_d;
    logic            discard_q, discard_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [PW-1:0]   pix_q, pix_d;
    logic            underflow_q, underflow_d;
    logic [SW-1:0]   sub_q, sub_d;
    logic            phase_q, phase_d;
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [DW-1:0]   fifo_mem_q [DEPTH];

    logic            vsync_rise;
    logic            flush;
    logic            ack_live;
    logic            push;
    logic            pop;
    logic            demand;
    logic            fifo_empty;
    logic [DW-1:0]   head_word;
    logic [PW-1:0]   head_pix;

    assign vsync_rise = vsync & ~vsync_prev_q;
    // A disabled block behaves exactly like one being flushed every cycle.
    assign flush      = vsync_rise | ~enable;
    // An ack only matters when a request is actually in flight; this is what
    // makes a late ack after reset harmless.
    assign ack_live   = mem_ack & outstanding_q;
    // Data is kept only for a live, non-discarded request, and never in a
    // flush cycle (the FIFO is being cleared anyway).
    assign push       = ack_live & ~discard_q & ~flush;
    assign demand     = ce_pix & ~hblank & ~vblank;
    assign fifo_empty = (count_q == '0);
    assign head_word  = fifo_mem_q[rd_ptr_q];

    always_comb begin
        head_pix = '0;
        for (int k = 0; k < N; k++) begin
            if (sub_q == SW'(k)) head_pix = head_word[k*PW +: PW];
        end
    end

    always_comb begin
        vsync_prev_d  = vsync;
        mem_req_d     = 1'b0;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        addr_d        = addr_q;
        pix_d         = pix_q;
        underflow_d   = underflow_q;
        sub_d         = sub_q;
        phase_d       = phase_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        pop           = 1'b0;

        // Request level: held until its ack, dropped for at least one cycle
        // after each ack, and only raised from idle when the word fits.
        // The space test uses the registered count, so a pop out of a full
        // FIFO lets the next request out one cycle later.
        if (flush || ack_live) begin
            mem_req_d = 1'b0;
        end else if (mem_req_q) begin
            mem_req_d = 1'b1;
        end else begin
            mem_req_d = ~discard_q & ~outstanding_q & (count_q < CW'(DEPTH));
        end

        if (ack_live) begin
            outstanding_d = 1'b0;
            discard_d     = 1'b0;
        end else begin
            if (mem_req_d && !mem_req_q) outstanding_d = 1'b1;
            // A request caught by a flush still completes; its data is dropped.
            if (flush && outstanding_q) discard_d = 1'b1;
        end

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            sub_d       = '0;
            phase_d     = 1'b0;
            underflow_d = 1'b0;
            addr_d      = BASE;
            pix_d       = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTRW'(1);
                addr_d   = addr_q + AW'(1);
            end

            if (ce_pix) begin
                if (!demand) begin
                    // Blanking: sub and phase hold so the next line continues
                    // mid-word through the linear framebuffer.
                    pix_d = '0;
                end else if (fifo_empty) begin
                    pix_d       = '0;
                    underflow_d = 1'b1;
                end else begin
                    pix_d = head_pix;
                    if (!repeat2 || phase_q) begin
                        if (sub_q == SW'(N - 1)) begin
                            sub_d = '0;
                            pop   = 1'b1;
                        end else begin
                            sub_d = sub_q + SW'(1);
                        end
                    end
                    phase_d = repeat2 & ~phase_q;
                end
            end

            if (pop) rd_ptr_d = rd_ptr_q + PTRW'(1);

            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_prev_q  <= 1'b0;
            mem_req_q     <= 1'b0;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            addr_q        <= BASE;
            pix_q         <= '0;
            underflow_q   <= 1'b0;
            sub_q         <= '0;
            phase_q       <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            vsync_prev_q  <= vsync_prev_d;
            mem_req_q     <= mem_req_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            addr_q        <= addr_d;
            pix_q         <= pix_d;
            underflow_q   <= underflow_d;
            sub_q         <= sub_d;
            phase_q       <= phase_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // Storage needs no reset: count/pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= mem_data;
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = addr_q;
    assign pix_out   = pix_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_overlay_fetch.sv
// tb_overlay_fetch
//   Randomised bench for overlay_fetch. A memory model answers requests with
//   a word whose pixels equal their frame pixel index, so the reference model
//   works at pixel level: pixels fetched this frame, pixels consumed, repeat
//   phase and the sticky underflow flag. Expected (underflow, pixel) pairs are
//   queued per ce_pix and checked by an independent monitor.
module tb_overlay_fetch;

    localparam int            AW    = 24;
    localparam int            DW    = 32;
    localparam int            PW    = 16;
    localparam int            DEPTH = 4;
    localparam int            N     = DW / PW;
    localparam logic [AW-1:0] BASE  = 24'h000040;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          ce_pix = 1'b0;
    logic          hblank = 1'b0;
    logic          vblank = 1'b0;
    logic          vsync = 1'b0;
    logic          repeat2 = 1'b0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_data = '0;
    logic [PW-1:0] pix_out;
    logic          underflow;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    overlay_fetch #(
        .AW(AW), .DW(DW), .PW(PW), .DEPTH(DEPTH), .BASE(BASE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ce_pix(ce_pix),
        .hblank(hblank), .vblank(vblank), .vsync(vsync), .repeat2(repeat2),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_data(mem_data), .pix_out(pix_out), .underflow(underflow)
    );

    // ---------------- scoreboard ----------------
    int            n_cmp = 0;
    int            n_err = 0;
    logic [PW:0]   exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : monitor
        logic [PW:0] e;
        if (rst_n && ce_pix) begin
            #1;
            if (exp_q.size() == 0) begin
                check("exp_q_underrun", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("pix_out", pix_out, e[PW-1:0]);
                check("underflow", underflow, e[PW]);
            end
        end
    end

    // ---------------- reference model state ----------------
    int            avail, consumed, words;
    bit            phase_m, uf_m, vprev_m;
    bit            pending, disc;
    int            cnt;
    logic [AW-1:0] req_addr;
    int            req_seen;
    bit            prev_flush, ack_prev;
    int            lat_min, lat_max;
    int            ce_period, ce_ctr, h_act, h_tot, hpos;
    bit            vsync_drv, vblank_drv, enable_drv;

    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        int            i;
        w = '0;
        i = int'(a - BASE);
        for (int k = 0; k < N; k++) w[k*PW +: PW] = PW'(i * N + k);
        return w;
    endfunction

    task automatic model_clear();
        avail = 0; consumed = 0; words = 0;
        phase_m = 1'b0; uf_m = 1'b0;
    endtask

    // One clock of stimulus + model, executed at the falling edge.
    task automatic do_cycle();
        bit          flush, dem, ce, hb, ack_now, accept;
        logic [PW:0] e;
        @(negedge clk);
        // properties of the registered request state
        if ((words - consumed / N) >= DEPTH) check("mem_req_when_full", mem_req, 1'b0);
        if (pending && disc) check("mem_req_during_discard", mem_req, 1'b0);
        if (prev_flush) check("mem_req_after_flush", mem_req, 1'b0);
        if (ack_prev) check("mem_req_drop_after_ack", mem_req, 1'b0);

        ce = (ce_ctr == 0);
        ce_ctr = (ce_ctr + 1) % ce_period;
        hb = (hpos >= h_act);
        if (ce) hpos = (hpos + 1) % h_tot;

        flush = (vsync_drv && !vprev_m) || !enable_drv;
        vprev_m = vsync_drv;

        ack_now = 1'b0;
        accept = 1'b0;
        if (pending) begin
            cnt--;
            if (cnt == 0) begin
                ack_now = 1'b1;
                mem_data = word_of(req_addr);
                accept = !disc && !flush;
                pending = 1'b0;
            end
        end else if (mem_req) begin
            check("mem_addr", mem_addr, BASE + AW'(words));
            req_addr = mem_addr;
            req_seen++;
            pending = 1'b1;
            disc = 1'b0;
            cnt = $urandom_range(lat_max, lat_min);
        end
        if (pending && flush) disc = 1'b1;
        ack_prev = ack_now;

        dem = ce && !hb && !vblank_drv;
        if (flush) begin
            e = '0;
            model_clear();
        end else begin
            e = {uf_m, PW'(0)};
            if (dem) begin
                if (consumed >= avail) begin
                    uf_m = 1'b1;
                    e = {1'b1, PW'(0)};
                end else begin
                    e = {uf_m, PW'(consumed)};
                    if (!repeat2 || phase_m) consumed++;
                    phase_m = repeat2 ? !phase_m : 1'b0;
                end
            end
            if (accept) begin
                avail += N;
                words++;
            end
        end
        prev_flush = flush;
        if (ce) exp_q.push_back(e);

        ce_pix = ce; hblank = hb; vblank = vblank_drv;
        vsync = vsync_drv; enable = enable_drv; mem_ack = ack_now;
    endtask

    // ---------------- driver tasks ----------------
    task automatic run(input int n);
        repeat (n) do_cycle();
    endtask

    task automatic vsync_pulse();
        vsync_drv = 1'b1;
        run(3);
        vsync_drv = 1'b0;
    endtask

    task automatic set_video(input int cep, input int ha, input int ht, input int lmin, input int lmax);
        ce_period = cep; ce_ctr = 0;
        h_act = ha; h_tot = ht; hpos = 0;
        lat_min = lmin; lat_max = lmax;
    endtask

    task automatic model_reset();
        model_clear();
        pending = 1'b0; disc = 1'b0; cnt = 0;
        vprev_m = 1'b0; prev_flush = 1'b0; ack_prev = 1'b0;
        ce_ctr = 0;
    endtask

    // Async reset mid-cycle, checked immediately; a late ack is presented on
    // the release edge and must be ignored.
    task automatic reset_mid(input bit late_ack);
        @(negedge clk);
        ce_pix = 1'b0; mem_ack = 1'b0; vsync = 1'b0; vsync_drv = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, BASE);
        check("rst_pix_out", pix_out, '0);
        check("rst_underflow", underflow, 1'b0);
        repeat (2) @(negedge clk);
        model_reset();
        exp_q.delete();
        rst_n = 1'b1;
        if (late_ack) begin
            mem_ack = 1'b1;
            mem_data = DW'($urandom);
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : main
        int r0;
        req_seen = 0;
        enable_drv = 1'b1; vsync_drv = 1'b0; vblank_drv = 1'b0;
        set_video(8, 1000, 1000, 3, 3);
        model_reset();
        repeat (3) @(negedge clk);
        check("init_mem_req", mem_req, 1'b0);
        check("init_mem_addr", mem_addr, BASE);
        check("init_pix_out", pix_out, '0);
        check("init_underflow", underflow, 1'b0);
        rst_n = 1'b1;

        // basic stream
        repeat2 = 1'b0;
        vsync_pulse();
        run(400);

        // pixel doubling
        repeat2 = 1'b1;
        vsync_pulse();
        run(400);
        repeat2 = 1'b0;

        // underflow: slow memory, fast pixels
        set_video(2, 1000, 1000, 40, 40);
        vsync_pulse();
        run(300);
        @(posedge clk); #1;
        check("underflow_sticky", underflow, uf_m);
        vsync_drv = 1'b1;
        do_cycle();
        @(posedge clk); #1;
        check("underflow_cleared", underflow, 1'b0);
        check("addr_after_vsync", mem_addr, BASE);
        run(2);
        vsync_drv = 1'b0;
        run(100);

        // vsync edge one cycle before an ack
        set_video(8, 1000, 1000, 6, 6);
        vsync_pulse();
        run(20);
        for (int i = 0; i < 300 && !(pending && cnt == 2); i++) do_cycle();
        if (!(pending && cnt == 2)) begin
            n_cmp++; n_err++;
            $display("FAIL wait_mid_request: no request in flight within bound");
        end
        vsync_drv = 1'b1;
        do_cycle();
        do_cycle();
        @(posedge clk); #1;
        check("addr_after_discard", mem_addr, BASE);
        check("req_low_at_discard_ack", mem_req, 1'b0);
        run(2);
        vsync_drv = 1'b0;
        run(150);

        // full FIFO during long blanking
        set_video(4, 1000, 1000, 3, 3);
        vblank_drv = 1'b1;
        vsync_pulse();
        r0 = req_seen;
        run(100);
        check("full_req_count", req_seen - r0, DEPTH);
        check("full_mem_req_low", mem_req, 1'b0);
        vblank_drv = 1'b0;
        run(150);

        // reset during an outstanding request, late ack ignored
        for (int i = 0; i < 100 && !pending; i++) do_cycle();
        reset_mid(1'b1);
        run(100);

        // disable holds the block flushed; re-enable restarts at BASE
        enable_drv = 1'b0;
        run(60);
        enable_drv = 1'b1;
        run(150);

        // randomised frames
        for (int r = 0; r < 8; r++) begin
            int ha;
            ha = $urandom_range(40, 8);
            set_video($urandom_range(6, 1), ha, ha + $urandom_range(10, 0), 1, $urandom_range(12, 1));
            repeat2 = 1'($urandom_range(1, 0));
            vblank_drv = 1'($urandom_range(1, 0));
            vsync_pulse();
            run($urandom_range(30, 0));
            vblank_drv = 1'b0;
            run($urandom_range(400, 200));
            if ($urandom_range(1, 0) == 1) begin
                vsync_pulse();
                run(100);
            end
        end

        ce_ctr = 1;
        ce_period = 1000;
        run(5);
        @(posedge clk); #2;
        check("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/overlay_fetch.md
# overlay_fetch

Parametrised overlay pixel streamer for the arcade video path. It reads packed background/overlay pixels, RGBA4444 by default, from word-wide SDRAM through a single-outstanding request/acknowledge port. Words are buffered in a small FIFO, unpacked, and one pixel per active `ce_pix` is presented to the blend stage. It restarts at every vsync rising edge and adds optional horizontal pixel doubling and underflow reporting.

## Interface
- `AW`, default 24: memory word address width.
- `DW`, default 32: memory word width; must be an integer multiple of `PW`.
- `PW`, default 16: pixel width; N = DW/PW pixels per word.
- `DEPTH`, default 4: FIFO depth in words; power of 2, ≥2.
- `BASE`, default 0: word address of the first pixel of a frame.

Ports:
- `clk`  in  1  sole clock, video clock domain.
- `rst_n`  in  1  reset; **one clock; reset is asynchronous and active-low**.
- `enable`  in  1  overlay present; when 0, the block behaves as a held flush.
- `ce_pix`  in  1  pixel clock enable.
- `hblank`, `vblank`  in  1 each  active-high blanking.
- `vsync`  in  1  active-high vertical sync.
- `repeat2`  in  1  when 1, each pixel is shown for 2 active `ce_pix`.
- `mem_req`  out  1  read request (level).
- `mem_addr`  out  AW  word address, stable while `mem_req`=1.
- `mem_ack`  in  1  one-cycle pulse; `mem_data` valid this cycle.
- `mem_data`  in  DW  read data.
- `pix_out`  out  PW  current overlay pixel.
- `underflow`  out  1  sticky per frame; pixel demanded while FIFO empty.

## Operation
- **Reset values:** `mem_req`=0, `mem_addr`=BASE, `pix_out`=0, `underflow`=0. FIFO empty, sub-index 0, repeat phase 0, outstanding 0, flush 0.
- **Flush trigger:** vsync rising edge, i.e. `vsync`=1 and registered prev=0, sampled every clk and not gated by `ce_pix`.
  - Clears the FIFO, sub-index, repeat phase and `underflow`.
  - Sets `mem_addr`=BASE.
- **In-flight request at flush:** the request is allowed to complete. Its ack is discarded (discard flag), and `mem_req` stays 0 until that ack arrives.
- **Fetch:** `mem_req` next = `enable` & ~flush & ~discard & (fifo_count + outstanding + 1 ≤ DEPTH).
  - At most 1 outstanding request.
  - On a cycle with `mem_ack`=1 and no discard: push `mem_data`, increment `mem_addr` (wraps modulo 2^AW), and drop `mem_req` for ≥1 cycle.
- **Unpack:** pixel k of a word is `mem_data[k*PW +: PW]`, k=0 first.
- **Demand:** a cycle with `ce_pix` & ~`hblank` & ~`vblank`.
  - If FIFO empty: `pix_out`←0, `underflow`←1, no state advances.
  - Else `pix_out`←FIFO head pixel[sub].
    - If `repeat2`=0 or repeat phase=1: advance sub. If sub=N-1, sub←0 and pop.
    - Toggle repeat phase when `repeat2`=1; otherwise hold it at 0.
- **Blank:** `ce_pix` during blanking sets `pix_out`←0. Sub and phase hold, so a line continues mid-word as a linear framebuffer.
- **Disable:** `enable`=0 holds `pix_out`=0 and keeps the block flushed. A rising `enable` restarts at BASE without waiting for vsync.

## Timing
- `pix_out` is registered and updates on the clk edge of the demand cycle.
- Flush completes in the cycle after the vsync edge is detected. Earliest `mem_req` is 1 clk after that, i.e. 2 clks after `vsync` is sampled high.
- **Ack turnaround:** ack in cycle t means data is poppable from t+1. `mem_req` is low at t+1 and re-asserts at t+2 if space remains.
- **Push and pop in the same cycle:** count unchanged. Full FIFO plus pop: no request is issued that cycle; request at next cycle.
- **Ack coincident with vsync edge:** data discarded, `mem_addr`=BASE.
- **Async reset mid-request:** all state returns to reset values immediately. A late `mem_ack` after reset is ignored (outstanding=0).

## Test plan
1. **Basic stream.** Defaults, memory returns word i = {16'(2i+1),16'(2i)}, ack latency 3, `ce_pix` every 8 clk, active line. Required: `pix_out` sequence 0,1,2,3,… with no underflow; `mem_addr` after frame start counts BASE, BASE+1, ….
2. **Pixel doubling.** `repeat2`=1, same data as test 1. Required: `pix_out` 0,0,1,1,2,2 and half the fetch rate.
3. **Underflow.** Ack latency 40 clk, `ce_pix` every 2 clk. Required: `pix_out`=0 and `underflow`=1 on starved demands; no pixel skipped once data arrives; the next vsync edge clears `underflow`.
4. **Vsync mid-request.** Assert the vsync edge one cycle before `mem_ack`. Required: that word is not pushed, `mem_req` stays 0 until the ack, the next `mem_addr` is BASE, and the first pixel is 0.
5. **Full FIFO.** DEPTH=4, hold blanking for 100 clk. Required: exactly 4 acks accepted, `mem_req` stays 0 after that, and the first active demand outputs the pixel at BASE word 0.
6. **Reset and enable.** Apply `rst_n` low during an outstanding request, then a late `mem_ack`. Required: all outputs read 0 or BASE and the ack is ignored. With `enable`=0, `pix_out` stays 0 and no `mem_req` is issued.
